// File: rtl/t5_dwbs_pkg.sv
// t5_pkg: shared constants and state encoding for the t5 data-bus responder.
package t5_pkg;

  localparam int XLEN_C = 32;
  localparam int NLANE  = XLEN_C / 8;
  localparam int WCNT_W = 4;

  typedef enum logic [1:0] {
    DWBS_IDLE = 2'd0,
    DWBS_WAIT = 2'd1,
    DWBS_ACK  = 2'd2
  } dwbs_state_e;

endpackage

// File: rtl/t5_dwbs_ram.sv
// t5_dwbs_ram: single-port RAM, per-byte write enables, registered read port.
// The read register is cleared by reset so the bus read data starts at zero;
// the array itself is never cleared.
module t5_dwbs_ram
  import t5_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW   = 12
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [NLANE-1:0]  be_i,
  input  logic [AW-3:0]     addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic [XLEN-1:0]   rdata_o
);

  logic [XLEN-1:0] mem [2**(AW-2)];
  logic [XLEN-1:0] rdata_q;

  // Byte-lane writes; lanes with a clear enable keep their old contents.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < NLANE; i++) begin
        if (be_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  // Registered full-word read, held until the next read.
  always_ff @(posedge clk_i) begin
    if (!rstn_i)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/t5_dwbs.sv
// t5_dwbs: Wishbone classic data-bus responder backed by local byte-writable RAM.
// Inserts WAIT wait states, then performs the access and pulses dwb_ack for
// one cycle. Optional macro T5_DWBS_RDZERO_EN: dwb_dti is zero except during
// the ack cycle of a read (for wired-OR read-data muxing).
//
// Handshake: a transfer starts when dwb_cyc & dwb_stb are seen in IDLE; the
// initiator holds stb until the ack cycle. Dropping cyc or stb while waiting
// aborts the transfer with no ack and no write. After the ack cycle the
// responder always returns to IDLE, so a still-high stb is a new transfer.
module t5_dwbs
  import t5_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW   = 12,
  parameter int WAIT = 1
) (
  input  logic            sys_clk,
  input  logic            sys_rstn,
  input  logic            dwb_cyc,
  input  logic            dwb_stb,
  input  logic            dwb_wre,
  input  logic [3:0]      dwb_sel,
  input  logic [AW-1:0]   dwb_adr,
  input  logic [XLEN-1:0] dwb_dto,
  output logic [XLEN-1:0] dwb_dti,
  output logic            dwb_ack
);

  localparam logic [WCNT_W-1:0] WAIT_LOAD = (WAIT > 0) ? WCNT_W'(WAIT - 1) : '0;

  dwbs_state_e       state_q, state_d;
  logic [WCNT_W-1:0] cnt_q, cnt_d;
  logic [AW-3:0]     word_q;
  logic              wre_q;
  logic [3:0]        sel_q;
  logic [XLEN-1:0]   dto_q;

  logic              req, latch, go_ack;
  logic [AW-3:0]     acc_word;
  logic              acc_wre;
  logic [3:0]        acc_sel;
  logic [XLEN-1:0]   acc_dto;
  logic              ram_we, ram_re;
  logic [XLEN-1:0]   ram_rdata;
  logic              adr_lsb_unused;

  assign req            = dwb_cyc & dwb_stb;
  assign adr_lsb_unused = ^dwb_adr[1:0];

  // Next state, counter and the "access happens on this edge" strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    go_ack  = 1'b0;
    case (state_q)
      DWBS_IDLE: begin
        if (req) begin
          latch = 1'b1;
          if (WAIT == 0) begin
            state_d = DWBS_ACK;
            go_ack  = 1'b1;
          end else begin
            state_d = DWBS_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      DWBS_WAIT: begin
        if (!req) begin
          state_d = DWBS_IDLE;
        end else if (cnt_q == '0) begin
          state_d = DWBS_ACK;
          go_ack  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DWBS_ACK: state_d = DWBS_IDLE;
      default:  state_d = DWBS_IDLE;
    endcase
  end

  // With zero wait states the access happens on the sampling edge itself, so
  // IDLE uses the live bus; otherwise the latched request is used.
  always_comb begin
    if (state_q == DWBS_IDLE) begin
      acc_word = dwb_adr[AW-1:2];
      acc_wre  = dwb_wre;
      acc_sel  = dwb_sel;
      acc_dto  = dwb_dto;
    end else begin
      acc_word = word_q;
      acc_wre  = wre_q;
      acc_sel  = sel_q;
      acc_dto  = dto_q;
    end
  end

  // State register and wait counter.
  always_ff @(posedge sys_clk) begin
    if (!sys_rstn) begin
      state_q <= DWBS_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request when it is accepted in IDLE.
  always_ff @(posedge sys_clk) begin
    if (latch) begin
      word_q <= dwb_adr[AW-1:2];
      wre_q  <= dwb_wre;
      sel_q  <= dwb_sel;
      dto_q  <= dwb_dto;
    end
  end

  // Reset wins over a pending access: nothing commits on a reset edge.
  assign ram_we = go_ack &  acc_wre & sys_rstn;
  assign ram_re = go_ack & ~acc_wre & sys_rstn;

  t5_dwbs_ram #(
    .XLEN (XLEN),
    .AW   (AW)
  ) u_ram (
    .clk_i   (sys_clk),
    .rstn_i  (sys_rstn),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .be_i    (acc_sel),
    .addr_i  (acc_word),
    .wdata_i (acc_dto),
    .rdata_o (ram_rdata)
  );

  assign dwb_ack = (state_q == DWBS_ACK);

`ifdef T5_DWBS_RDZERO_EN
  assign dwb_dti = (state_q == DWBS_ACK && !wre_q) ? ram_rdata : '0;
`else
  assign dwb_dti = ram_rdata;
`endif

endmodule

// File: tb/tb_t5_dwbs.sv
// tb_t5_dwbs: bench for t5_dwbs; three responders with WAIT = 0, 2, 3 share
// the bus signals and each has its own dwb_cyc select.
module tb_t5_dwbs;

  localparam int NI = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic [NI-1:0] cyc;
  logic          stb, wre;
  logic [3:0]    sel;
  logic [11:0]   adr;
  logic [31:0]   dto;
  logic [NI-1:0] ack;
  logic [31:0]   dti [NI];

  t5_dwbs #(.XLEN(32), .AW(12), .WAIT(0)) u_w0 (
    .sys_clk(clk), .sys_rstn(rstn), .dwb_cyc(cyc[0]), .dwb_stb(stb), .dwb_wre(wre),
    .dwb_sel(sel), .dwb_adr(adr), .dwb_dto(dto), .dwb_dti(dti[0]), .dwb_ack(ack[0]));
  t5_dwbs #(.XLEN(32), .AW(12), .WAIT(2)) u_w2 (
    .sys_clk(clk), .sys_rstn(rstn), .dwb_cyc(cyc[1]), .dwb_stb(stb), .dwb_wre(wre),
    .dwb_sel(sel), .dwb_adr(adr), .dwb_dto(dto), .dwb_dti(dti[1]), .dwb_ack(ack[1]));
  t5_dwbs #(.XLEN(32), .AW(12), .WAIT(3)) u_w3 (
    .sys_clk(clk), .sys_rstn(rstn), .dwb_cyc(cyc[2]), .dwb_stb(stb), .dwb_wre(wre),
    .dwb_sel(sel), .dwb_adr(adr), .dwb_dto(dto), .dwb_dti(dti[2]), .dwb_ack(ack[2]));

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q [$];
  logic [31:0] last_rd [NI];

  function automatic int wait_of(input int k);
    if (k == 0) return 0;
    else if (k == 1) return 2;
    else return 3;
  endfunction

  function automatic logic [31:0] idle_dti(input int k);
`ifdef T5_DWBS_RDZERO_EN
    return 32'h0;
`else
    return last_rd[k];
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge; drives one transfer to responder k,
  // checks ack latency, read data on ack, and the idle cycle that follows.
  task automatic xfer(input int k, input logic w, input logic [3:0] s,
                      input logic [31:0] bus_adr, input logic [31:0] d,
                      input logic [31:0] exp_rd);
    int          lat;
    bit          got;
    logic [31:0] e;
    if (!w) exp_q.push_back(exp_rd);
    cyc[k] = 1'b1; stb = 1'b1; wre = w; sel = s; adr = bus_adr[11:0]; dto = d;
    lat = 0; got = 0;
    while (!got && lat <= 20) begin
      @(negedge clk);
      if (ack[k]) begin
        got = 1;
        if (!w) begin
          e = exp_q.pop_front();
          check($sformatf("rd_data k%0d adr %h", k, bus_adr), dti[k], e);
          last_rd[k] = e;
        end else begin
`ifdef T5_DWBS_RDZERO_EN
          check($sformatf("wr_ack_dti_zero k%0d", k), dti[k], 32'h0);
`endif
        end
      end else begin
        lat++;
      end
      @(posedge clk); #1;
    end
    if (!got && !w) e = exp_q.pop_front();
    check($sformatf("latency k%0d adr %h", k, bus_adr), lat, wait_of(k) + 1);
    cyc[k] = 1'b0; stb = 1'b0;
    @(negedge clk);
    check($sformatf("ack_single k%0d", k), {31'b0, ack[k]}, 32'h0);
    check($sformatf("dti_idle k%0d", k), dti[k], idle_dti(k));
    @(posedge clk); #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          k;
    logic        w;
    logic [3:0]  s;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] e;
  } vec_t;

  vec_t tbl [19];

  initial begin
    tbl[0]  = '{1, 1'b1, 4'hF, 32'h0000_0010, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{1, 1'b0, 4'hF, 32'h0000_0010, 32'h0,        32'hDEADBEEF};
    tbl[2]  = '{1, 1'b1, 4'h1, 32'h0000_0010, 32'h000000AA, 32'h0};
    tbl[3]  = '{1, 1'b0, 4'h0, 32'h0000_0010, 32'h0,        32'hDEADBEAA};
    tbl[4]  = '{1, 1'b1, 4'hF, 32'h1000_0004, 32'hCAFEF00D, 32'h0};
    tbl[5]  = '{1, 1'b0, 4'hF, 32'hFFFF_F004, 32'h0,        32'hCAFEF00D};
    tbl[6]  = '{1, 1'b1, 4'h0, 32'h0000_0004, 32'h00000000, 32'h0};
    tbl[7]  = '{1, 1'b0, 4'hF, 32'h0000_0004, 32'h0,        32'hCAFEF00D};
    tbl[8]  = '{1, 1'b1, 4'hF, 32'h0000_0040, 32'h0A0B0C0D, 32'h0};
    tbl[9]  = '{1, 1'b0, 4'hF, 32'h0000_0040, 32'h0,        32'h0A0B0C0D};
    tbl[10] = '{0, 1'b1, 4'hF, 32'h0000_0000, 32'h11223344, 32'h0};
    tbl[11] = '{0, 1'b1, 4'hF, 32'h0000_0004, 32'h55667788, 32'h0};
    tbl[12] = '{0, 1'b0, 4'hF, 32'h0000_0000, 32'h0,        32'h11223344};
    tbl[13] = '{2, 1'b1, 4'hF, 32'h0000_0020, 32'h12345678, 32'h0};
    tbl[14] = '{2, 1'b0, 4'hF, 32'h0000_0020, 32'h0,        32'h12345678};
    tbl[15] = '{0, 1'b1, 4'hC, 32'h0000_0000, 32'hAABB0000, 32'h0};
    tbl[16] = '{0, 1'b0, 4'hF, 32'h0000_0000, 32'h0,        32'hAABB3344};
    tbl[17] = '{0, 1'b1, 4'hF, 32'h0000_0FFC, 32'h0F0F0F0F, 32'h0};
    tbl[18] = '{0, 1'b0, 4'hF, 32'h0000_0FFC, 32'h0,        32'h0F0F0F0F};
  end

  // ---------------- test sequence ----------------
  initial begin
    rstn = 1'b0; cyc = '0; stb = 1'b0; wre = 1'b0; sel = 4'h0; adr = '0; dto = '0;
    for (int k = 0; k < NI; k++) last_rd[k] = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("reset_ack k%0d", k), {31'b0, ack[k]}, 32'h0);
      check($sformatf("reset_dti k%0d", k), dti[k], 32'h0);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    // Table-driven transfers
    for (int i = 0; i < 19; i++) begin
      xfer(tbl[i].k, tbl[i].w, tbl[i].s, tbl[i].a, tbl[i].d, tbl[i].e);
    end

    // WAIT=0, strobe held across two reads: acks in cycles 1 and 3 only
    cyc[0] = 1'b1; stb = 1'b1; wre = 1'b0; sel = 4'hF; adr = 12'h000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("b2b_ack c%0d", c), {31'b0, ack[0]}, (c == 1 || c == 3) ? 32'h1 : 32'h0);
      if (c == 1) check("b2b_rd0", dti[0], 32'hAABB3344);
      if (c == 3) check("b2b_rd1", dti[0], 32'h55667788);
      @(posedge clk); #1;
      if (c == 1) adr = 12'h004;
      if (c == 3) begin cyc[0] = 1'b0; stb = 1'b0; end
    end
    last_rd[0] = 32'h55667788;

    // WAIT=3, write strobe dropped in cycle 2: no ack, no write
    cyc[2] = 1'b1; stb = 1'b1; wre = 1'b1; sel = 4'hF; adr = 12'h020; dto = 32'hFFFFFFFF;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("abort_ack c%0d", c), {31'b0, ack[2]}, 32'h0);
      @(posedge clk); #1;
      if (c == 1) begin cyc[2] = 1'b0; stb = 1'b0; end
    end
    xfer(2, 1'b0, 4'hF, 32'h0000_0020, 32'h0, 32'h12345678);

    // WAIT=2 write interrupted by reset in cycle 1: no ack, word unchanged
    cyc[1] = 1'b1; stb = 1'b1; wre = 1'b1; sel = 4'hF; adr = 12'h040; dto = 32'h11111111;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("rst_mid_ack c%0d", c), {31'b0, ack[1]}, 32'h0);
      if (c == 2) begin
        for (int k = 0; k < NI; k++) check($sformatf("rst_mid_dti k%0d", k), dti[k], 32'h0);
      end
      @(posedge clk); #1;
      if (c == 0) rstn = 1'b0;
      if (c == 1) begin cyc[1] = 1'b0; stb = 1'b0; end
      if (c == 2) rstn = 1'b1;
    end
    for (int k = 0; k < NI; k++) last_rd[k] = 32'h0;
    xfer(1, 1'b0, 4'hF, 32'h0000_0040, 32'h0, 32'h0A0B0C0D);
    xfer(0, 1'b0, 4'hF, 32'h0000_0004, 32'h0, 32'h55667788);

    check("sb_queue_empty", exp_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
